// File: rtl/fb_pipe_flow_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fb_pipe_flow_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - FSM state encodings (RUN/JALR/FLUSH/MEMWAIT, visible on o_state)
//   - counter width FB_32BITS and the small wait-counter width
//   - the bundle of pipeline-register controls and helper functions that
//     build the common control patterns.
// -----------------------------------------------------------------------------
package fb_pipe_flow_ctrl_pkg;

   localparam int FB_32BITS     = 32;
   // Wide enough for the largest wait/flush reload value (3).
   localparam int FB_FLOW_CNT_W = 2;

   typedef enum logic [1:0] {
      FB_FLOW_RUN     = 2'd0,
      FB_FLOW_JALR    = 2'd1,
      FB_FLOW_FLUSH   = 2'd2,
      FB_FLOW_MEMWAIT = 2'd3
   } fb_flow_state_e;

   typedef struct packed {
      logic jalr_en;
      logic pc_we;
      logic if_id_we;
      logic id_ex_we;
      logic ex_mem_we;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
   } fb_flow_ctrl_t;

   // Every stage advances, nothing is cleared.
   function automatic fb_flow_ctrl_t fb_flow_ctrl_all_we();
      fb_flow_ctrl_t c;
      c              = '0;
      c.pc_we        = 1'b1;
      c.if_id_we     = 1'b1;
      c.id_ex_we     = 1'b1;
      c.ex_mem_we    = 1'b1;
      return c;
   endfunction

   // Nothing moves; used for data-memory waits.
   function automatic fb_flow_ctrl_t fb_flow_ctrl_freeze();
      return '0;
   endfunction

   // Held in reset: registers frozen and cleared.
   function automatic fb_flow_ctrl_t fb_flow_ctrl_reset();
      fb_flow_ctrl_t c;
      c              = '0;
      c.if_id_flush  = 1'b1;
      c.id_ex_flush  = 1'b1;
      c.ex_mem_flush = 1'b1;
      return c;
   endfunction

   // Mispredict: PC loads the corrected target, the three younger
   // pipeline registers are squashed.
   function automatic fb_flow_ctrl_t fb_flow_ctrl_mispredict();
      fb_flow_ctrl_t c;
      c              = fb_flow_ctrl_all_we();
      c.if_id_flush  = 1'b1;
      c.id_ex_flush  = 1'b1;
      c.ex_mem_flush = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/fb_pipe_flow_ctrl_if.sv
// -----------------------------------------------------------------------------
// fb_pipe_flow_ctrl_if
// Hazard-event inputs and pipeline-register controls of the flow sequencer.
//   i_lock, i_predict_err, i_load_use, i_dmem_busy : hazard events in
//   o_jalr_en                                      : jalr target select pulse
//   o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we   : register write enables
//   o_if_id_flush, o_id_ex_flush, o_ex_mem_flush   : register sync clears
//   o_state                                        : FSM state (debug)
//   o_stall_cnt, o_flush_cnt                       : perf counters
// master : the hazard-unit / pipeline side; slave : the sequencer.
// -----------------------------------------------------------------------------
interface fb_pipe_flow_ctrl_if;
   import fb_pipe_flow_ctrl_pkg::*;

   logic                 i_lock;
   logic                 i_predict_err;
   logic                 i_load_use;
   logic                 i_dmem_busy;
   logic                 o_jalr_en;
   logic                 o_pc_we;
   logic                 o_if_id_we;
   logic                 o_id_ex_we;
   logic                 o_ex_mem_we;
   logic                 o_if_id_flush;
   logic                 o_id_ex_flush;
   logic                 o_ex_mem_flush;
   logic [1:0]           o_state;
   logic [FB_32BITS-1:0] o_stall_cnt;
   logic [FB_32BITS-1:0] o_flush_cnt;

   modport master (
      output i_lock, i_predict_err, i_load_use, i_dmem_busy,
      input  o_jalr_en, o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we,
      input  o_if_id_flush, o_id_ex_flush, o_ex_mem_flush,
      input  o_state, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_lock, i_predict_err, i_load_use, i_dmem_busy,
      output o_jalr_en, o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we,
      output o_if_id_flush, o_id_ex_flush, o_ex_mem_flush,
      output o_state, o_stall_cnt, o_flush_cnt
   );

endinterface

// File: rtl/fb_pipe_flow_ctrl_perf_counter.sv
// -----------------------------------------------------------------------------
// fb_pipe_flow_ctrl_perf_counter
// Free-running event counter, FB_32BITS wide, wraps modulo 2^32.
//   clk   : clock
//   rst_n : synchronous active-low clear
//   i_en  : count this cycle
//   o_cnt : current count
// -----------------------------------------------------------------------------
module fb_pipe_flow_ctrl_perf_counter
   import fb_pipe_flow_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_en,
   output logic [FB_32BITS-1:0] o_cnt
);

   logic [FB_32BITS-1:0] cnt_d;
   logic [FB_32BITS-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (i_en) begin
         cnt_d = cnt_q + FB_32BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/fb_pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// fb_pipe_flow_ctrl
// Central stall/flush sequencer of the 5-stage pipeline. Takes the hazard
// events (mispredict, jalr lock, load-use, data-memory wait) and drives the
// pipeline-register write enables and synchronous clears, and generates the
// one-cycle jalr_en pulse the control hazard unit expects after lock.
//
// Ports:
//   clk   : pipeline clock
//   rst_n : synchronous active-low reset
//   bus   : fb_pipe_flow_ctrl_if.slave (hazard inputs, enables, flushes,
//           debug state and perf counters)
// Parameters:
//   JALR_WAIT    : cycles spent in JALR before jalr_en fires (1..3)
//   FLUSH_CYCLES : cycles the flushes stay asserted after a mispredict (1..4)
// Configuration:
//   FB_FLOW_PERF_EN : when defined, o_stall_cnt / o_flush_cnt are live
//                     counters; otherwise both are tied to zero.
// Control outputs are combinational from the registered state and the
// current hazard inputs.
// -----------------------------------------------------------------------------
module fb_pipe_flow_ctrl
   import fb_pipe_flow_ctrl_pkg::*;
#(
   parameter int JALR_WAIT    = 1,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fb_pipe_flow_ctrl_if.slave   bus
);

   localparam logic [FB_FLOW_CNT_W-1:0] JALR_LOAD  = FB_FLOW_CNT_W'(JALR_WAIT - 1);
   localparam logic [FB_FLOW_CNT_W-1:0] FLUSH_LOAD = FB_FLOW_CNT_W'(FLUSH_CYCLES - 1);

   fb_flow_state_e             state_d;
   fb_flow_state_e             state_q;
   logic [FB_FLOW_CNT_W-1:0]   cnt_d;
   logic [FB_FLOW_CNT_W-1:0]   cnt_q;
   fb_flow_ctrl_t              ctrl;
   logic                       take_perr;

   // A mispredict waiting in a frozen EX/MEM is serviced only after the
   // memory wait ends, so it is not taken in MEMWAIT.
   assign take_perr = bus.i_predict_err && (state_q != FB_FLOW_MEMWAIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl    = fb_flow_ctrl_all_we();
      if (!rst_n) begin
         ctrl    = fb_flow_ctrl_reset();
         state_d = FB_FLOW_RUN;
         cnt_d   = '0;
      end else if (take_perr) begin
         // Mispredict beats everything, including a pending jalr, which is
         // abandoned because its instruction is on the wrong path.
         ctrl = fb_flow_ctrl_mispredict();
         if (FLUSH_CYCLES > 1) begin
            state_d = FB_FLOW_FLUSH;
            cnt_d   = FLUSH_LOAD;
         end else begin
            state_d = FB_FLOW_RUN;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            FB_FLOW_RUN: begin
               if (bus.i_dmem_busy) begin
                  ctrl    = fb_flow_ctrl_freeze();
                  state_d = FB_FLOW_MEMWAIT;
               end else if (bus.i_load_use) begin
                  // Hold IF and ID, push a bubble into EX.
                  ctrl.pc_we       = 1'b0;
                  ctrl.if_id_we    = 1'b0;
                  ctrl.id_ex_flush = 1'b1;
               end else if (bus.i_lock) begin
                  // jalr moves on into EX; fetch holds until the target is known.
                  ctrl.pc_we    = 1'b0;
                  ctrl.if_id_we = 1'b0;
                  state_d       = FB_FLOW_JALR;
                  cnt_d         = JALR_LOAD;
               end
            end
            FB_FLOW_JALR: begin
               if (bus.i_dmem_busy) begin
                  ctrl = fb_flow_ctrl_freeze();
               end else if (cnt_q != '0) begin
                  ctrl.pc_we    = 1'b0;
                  ctrl.if_id_we = 1'b0;
                  cnt_d         = cnt_q - FB_FLOW_CNT_W'(1);
               end else begin
                  // Load the jalr target and squash the instruction that
                  // was fetched while locked.
                  ctrl.jalr_en     = 1'b1;
                  ctrl.if_id_flush = 1'b1;
                  state_d          = FB_FLOW_RUN;
               end
            end
            FB_FLOW_FLUSH: begin
               if (bus.i_dmem_busy) begin
                  ctrl = fb_flow_ctrl_freeze();
               end else begin
                  // lock / load-use come from squashed instructions: ignored.
                  ctrl.if_id_flush = 1'b1;
                  ctrl.id_ex_flush = 1'b1;
                  cnt_d            = cnt_q - FB_FLOW_CNT_W'(1);
                  if (cnt_q <= FB_FLOW_CNT_W'(1)) begin
                     state_d = FB_FLOW_RUN;
                     cnt_d   = '0;
                  end
               end
            end
            FB_FLOW_MEMWAIT: begin
               if (bus.i_dmem_busy) begin
                  ctrl = fb_flow_ctrl_freeze();
               end else begin
                  state_d = FB_FLOW_RUN;
               end
            end
            default: begin
               state_d = FB_FLOW_RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FB_FLOW_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_jalr_en      = ctrl.jalr_en;
   assign bus.o_pc_we        = ctrl.pc_we;
   assign bus.o_if_id_we     = ctrl.if_id_we;
   assign bus.o_id_ex_we     = ctrl.id_ex_we;
   assign bus.o_ex_mem_we    = ctrl.ex_mem_we;
   assign bus.o_if_id_flush  = ctrl.if_id_flush;
   assign bus.o_id_ex_flush  = ctrl.id_ex_flush;
   assign bus.o_ex_mem_flush = ctrl.ex_mem_flush;
   assign bus.o_state        = state_q;

`ifdef FB_FLOW_PERF_EN
   logic stall_en;
   logic flush_en;

   // Reset already clears the counters, so the rst_n qualification is
   // implicit for the stall count.
   assign stall_en = !ctrl.pc_we;
   assign flush_en = take_perr && rst_n;

   fb_pipe_flow_ctrl_perf_counter u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (stall_en),
      .o_cnt (bus.o_stall_cnt)
   );

   fb_pipe_flow_ctrl_perf_counter u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (flush_en),
      .o_cnt (bus.o_flush_cnt)
   );
`else
   assign bus.o_stall_cnt = '0;
   assign bus.o_flush_cnt = '0;
`endif

endmodule
